// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter FSM states, BCD digit width and
// the display blanking constants used by the seven-segment path.
package calc_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned MAX_DIGITS  = 32;

    // Wide constants; users slice off the low DIGITS bits.
    localparam logic [MAX_DIGITS-1:0] MASK_SHOW_ZERO = {{(MAX_DIGITS - 1){1'b1}}, 1'b0};
    localparam logic [MAX_DIGITS-1:0] MASK_ERROR     = '0;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StMask,
        StDone
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/result bundle between the calculator fsm and the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 8
);
    import calc_pkg::*;

    logic                          start;
    logic [IN_W-1:0]               bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]             an_mask;
    logic                          overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, an_mask, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, an_mask, overflow
    );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with leading-zero blanking mask and overflow flag for the display path.
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DIGITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CntW = $clog2(IN_W + 1);
    localparam logic [DIGITS-1:0] MaskShowZero = MASK_SHOW_ZERO[DIGITS-1:0];
    localparam logic [DIGITS-1:0] MaskError    = MASK_ERROR[DIGITS-1:0];

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   bcd_sr_q, bcd_sr_d;
    logic [IN_W-1:0]   bin_sr_q, bin_sr_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0] an_mask_q, an_mask_d;
    logic              overflow_q, overflow_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [DIGITS-1:0] blank_mask;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_sr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Digit i blanks only when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero    = upper_zero & (bcd_sr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_mask[i] = upper_zero;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_sr_d   = bcd_sr_q;
        bin_sr_d   = bin_sr_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_d      = bcd_q;
        an_mask_d  = an_mask_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    bcd_sr_d  = '0;
                    bin_sr_d  = bus.bin;
                    ovf_acc_d = 1'b0;
                end
            end
            StShift: begin
                // A set MSB after adjustment is a carry out of the top digit.
                bcd_sr_d  = {bcd_adj[BcdW-2:0], bin_sr_q[IN_W-1]};
                bin_sr_d  = bin_sr_q << 1;
                ovf_acc_d = ovf_acc_q | bcd_adj[BcdW-1];
                cnt_d     = cnt_q + CntW'(1);
                if (cnt_q == CntW'(IN_W - 1)) begin
                    state_d = StMask;
                end
            end
            StMask: begin
                state_d = StDone;
                if (ovf_acc_q) begin
                    bcd_d      = '0;
                    an_mask_d  = MaskError;
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = bcd_sr_q;
                    an_mask_d  = blank_mask;
                    overflow_d = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bcd_sr_q   <= '0;
            bin_sr_q   <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_q      <= '0;
            an_mask_q  <= MaskShowZero;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_sr_q   <= bcd_sr_d;
            bin_sr_q   <= bin_sr_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_q      <= bcd_d;
            an_mask_q  <= an_mask_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.bcd      = bcd_q;
    assign bus.an_mask  = an_mask_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected results are queued at start
// and compared when done pulses, using an arithmetic decimal model.
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  mask;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_done;
    int   n_started;
    exp_t sb[$];

    bin_to_bcd_seq_if #(.IN_W(32), .DIGITS(8)) bus ();

    bin_to_bcd_seq #(
        .IN_W   (32),
        .DIGITS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v, input int due);
        exp_t            e;
        longint unsigned n;
        bit              lead;
        e.due  = due;
        e.bcd  = '0;
        e.mask = '0;
        e.ovf  = 1'b0;
        if (v > 32'd99_999_999) begin
            e.ovf = 1'b1;
        end else begin
            n = longint'(v);
            for (int i = 0; i < 8; i++) begin
                e.bcd[i*4 +: 4] = 4'(n % 10);
                n = n / 10;
            end
            lead = 1'b1;
            for (int i = 7; i > 0; i--) begin
                lead      = lead && (e.bcd[i*4 +: 4] == 4'd0);
                e.mask[i] = lead;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("bcd", 64'(bus.bcd), 64'(e.bcd));
                check_eq("an_mask", 64'(bus.an_mask), 64'(e.mask));
                check_eq("overflow", 64'(bus.overflow), 64'(e.ovf));
                check_eq("latency", 64'(cyc), 64'(e.due));
                check_eq("busy_at_done", 64'(bus.busy), 64'd1);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_bcd"}, 64'(bus.bcd), 64'd0);
        check_eq({tag, "_mask"}, 64'(bus.an_mask), 64'hFE);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    endtask

    task automatic wait_done();
        int waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(posedge clk);
            waited++;
        end
        check_eq("done_seen", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        check_eq("busy_after_done", 64'(bus.busy), 64'd0);
        check_eq("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    task automatic run(input logic [31:0] v);
        @(negedge clk);
        bus.bin   = v;
        bus.start = 1'b1;
        sb.push_back(model(v, cyc + 34));
        n_started++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = ~v;
        wait_done();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_done    = 0;
        n_started = 0;
        cyc       = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_values("reset_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run(32'h0000_04D2);
        run(32'd0);
        run(32'h05F5_E0FF);
        run(32'h05F5_E100);
        run(32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) run(32'($urandom_range(99_999_999, 0)));
        for (int i = 0; i < 2; i++) run(32'($urandom_range(32'hFFFF_FFFF, 32'd100_000_000)));

        // Reset ten edges into a conversion: no done, reset values back.
        @(negedge clk);
        bus.bin   = 32'd555;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("no_done_after_reset", 64'(n_done), 64'(n_started));

        run(32'd305);

        // Second start while busy is ignored; outputs hold the previous result.
        @(negedge clk);
        bus.bin   = 32'd42;
        bus.start = 1'b1;
        sb.push_back(model(32'd42, cyc + 34));
        n_started++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 32'd7;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        check_eq("hold_bcd", 64'(bus.bcd), 64'h305);
        check_eq("hold_mask", 64'(bus.an_mask), 64'hF8);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check_eq("done_count", 64'(n_done), 64'(n_started));
        check_eq("idle_busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
